// File: rtl/memory_pkg.sv
// Shared definitions for the simple-dual-port RAM and its clear sequencer.
package memory_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  function automatic int lane_count(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

endpackage

// File: rtl/memory_clr_seq.sv
// Clear sequencer: walks the array from address 0 to DEPTH-1 writing zero,
// one word per cycle, after reset or an accepted clr_req.
module memory_clr_seq #(
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              state_dbg
);
  import memory_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // clr_req arriving while a clear is already running is dropped on purpose.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign clr_we    = (state_q == ST_CLEAR);
  assign clr_addr  = cnt_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/memory_sdp.sv
// Simple-dual-port RAM with byte-lane writes, selectable read-during-write
// result, optional output register and a hardware clear sequencer.
module memory_sdp #(
  parameter int DATA_W  = 8,
  parameter int LANE_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int DEPTH   = 2**ADDR_W,
  parameter int BYPASS  = 1,
  parameter int OUT_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_req,
  output logic                     busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/LANE_W-1:0] wbe,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic [DATA_W-1:0]        rdata,
  output logic                     rvalid
);
  import memory_pkg::*;

  localparam int              LANES     = lane_count(DATA_W, LANE_W);
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_state;

  memory_clr_seq #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_clr_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_req   (clr_req),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .state_dbg (clr_state)
  );

  // Access protocol: re/we are sampled on a rising edge only while the
  // sequencer is idle and no clear is being requested that cycle; every
  // sampled re yields exactly one rvalid pulse 1 (or 2 with OUT_REG) cycles
  // later, in issue order, with no back-pressure.
  logic acc_ok, wr_in_range, rd_in_range, usr_we, rd_en;

  assign acc_ok      = (clr_state == ST_IDLE) && !clr_req && !rst;
  assign wr_in_range = ({1'b0, waddr} < DEPTH_EXT);
  assign rd_in_range = ({1'b0, raddr} < DEPTH_EXT);
  assign usr_we      = we && acc_ok && wr_in_range;
  assign rd_en       = re && acc_ok;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (usr_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (wbe[l]) mem_q[waddr][l*LANE_W +: LANE_W] <= wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  // Same-address collision: with BYPASS the enabled lanes are forwarded.
  logic [DATA_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_in_range) rd_word = mem_q[raddr];
    if ((BYPASS != 0) && usr_we && (waddr == raddr)) begin
      for (int l = 0; l < LANES; l++) begin
        if (wbe[l]) rd_word[l*LANE_W +: LANE_W] = wdata[l*LANE_W +: LANE_W];
      end
    end
  end

  logic [DATA_W-1:0] r1_data_q, r1_data_d;
  logic              r1_valid_q, r1_valid_d;

  always_comb begin
    r1_data_d  = rd_en ? rd_word : r1_data_q;
    r1_valid_d = rd_en;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_data_q  <= '0;
      r1_valid_q <= 1'b0;
    end else begin
      r1_data_q  <= r1_data_d;
      r1_valid_q <= r1_valid_d;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r2_data_q, r2_data_d;
      logic              r2_valid_q, r2_valid_d;

      always_comb begin
        r2_data_d  = r1_valid_q ? r1_data_q : r2_data_q;
        r2_valid_d = r1_valid_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r2_data_q  <= '0;
          r2_valid_q <= 1'b0;
        end else begin
          r2_data_q  <= r2_data_d;
          r2_valid_q <= r2_valid_d;
        end
      end

      assign rdata  = r2_data_q;
      assign rvalid = r2_valid_q;
    end else begin : g_no_out_reg
      assign rdata  = r1_data_q;
      assign rvalid = r1_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_memory_sdp.sv
// Directed bench for memory_sdp: five instances with different parameters
// share one stimulus bus; each check targets the instance it concerns.
module tb_memory_sdp;

  logic        clk = 1'b0;
  logic        rst, clr_req, we, re;
  logic [3:0]  waddr, raddr, wbe;
  logic [31:0] wdata;

  logic        busy0, busy1, busy2, busy3, busy4;
  logic        rvalid0, rvalid1, rvalid2, rvalid3, rvalid4;
  logic [7:0]  rdata0, rdata2, rdata3, rdata4;
  logic [31:0] rdata1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- DUT instances ----------------
  memory_sdp u_d0 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy0),
    .we(we), .waddr(waddr), .wdata(wdata[7:0]), .wbe(wbe[0:0]),
    .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0)
  );

  memory_sdp #(.DATA_W(32), .LANE_W(8)) u_d1 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy1),
    .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1)
  );

  memory_sdp #(.BYPASS(0)) u_d2 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy2),
    .we(we), .waddr(waddr), .wdata(wdata[7:0]), .wbe(wbe[0:0]),
    .re(re), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2)
  );

  memory_sdp #(.OUT_REG(1)) u_d3 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy3),
    .we(we), .waddr(waddr), .wdata(wdata[7:0]), .wbe(wbe[0:0]),
    .re(re), .raddr(raddr), .rdata(rdata3), .rvalid(rvalid3)
  );

  memory_sdp #(.DEPTH(12)) u_d4 (
    .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy4),
    .we(we), .waddr(waddr), .wdata(wdata[7:0]), .wbe(wbe[0:0]),
    .re(re), .raddr(raddr), .rdata(rdata4), .rvalid(rvalid4)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr_req = 1'b0; we = 1'b0; re = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wbe = '0;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    idle_inputs();
    we = 1'b1; waddr = a; wdata = d; wbe = be;
    tick();
    idle_inputs();
  endtask

  task automatic read(input logic [3:0] a);
    idle_inputs();
    re = 1'b1; raddr = a;
    tick();
    idle_inputs();
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;
    logic        re;
    logic [3:0]  raddr;
    logic        exp_valid;
    logic [31:0] exp_d1;   // 32-bit, BYPASS=1
    logic [7:0]  exp_d2;   // 8-bit, BYPASS=0
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n0, n1, n2, n3, n4, bad, first_idx, nvalid;

    vecs[0]  = '{1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, 4'd0, 1'b0, 32'h00000000, 8'h00};
    vecs[1]  = '{1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0, 1'b0, 32'h00000000, 8'h00};
    vecs[2]  = '{1'b0, 4'd0, 32'h00000000, 4'b0000, 1'b1, 4'd3, 1'b1, 32'hAA22CC44, 8'h44};
    vecs[3]  = '{1'b1, 4'd7, 32'h0000005A, 4'b0001, 1'b1, 4'd7, 1'b1, 32'h0000005A, 8'h00};
    vecs[4]  = '{1'b0, 4'd0, 32'h00000000, 4'b0000, 1'b1, 4'd7, 1'b1, 32'h0000005A, 8'h5A};
    vecs[5]  = '{1'b1, 4'd5, 32'hDEADBEEF, 4'b0000, 1'b1, 4'd5, 1'b1, 32'h00000000, 8'h00};
    vecs[6]  = '{1'b0, 4'd0, 32'h00000000, 4'b0000, 1'b1, 4'd5, 1'b1, 32'h00000000, 8'h00};
    vecs[7]  = '{1'b1, 4'd9, 32'h12345678, 4'b1010, 1'b1, 4'd3, 1'b1, 32'hAA22CC44, 8'h44};
    vecs[8]  = '{1'b0, 4'd0, 32'h00000000, 4'b0000, 1'b1, 4'd9, 1'b1, 32'h12005600, 8'h00};
    vecs[9]  = '{1'b1, 4'd9, 32'hFFFFFFFF, 4'b0100, 1'b1, 4'd9, 1'b1, 32'h12FF5600, 8'h00};
    vecs[10] = '{1'b0, 4'd0, 32'h00000000, 4'b0000, 1'b0, 4'd0, 1'b0, 32'h12FF5600, 8'h00};
    vecs[11] = '{1'b0, 4'd0, 32'h00000000, 4'b0000, 1'b1, 4'd9, 1'b1, 32'h12FF5600, 8'h00};

    // Reset and initial clear
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rvalid", {31'b0, rvalid0}, 32'd0);
    chk("rst_rdata", {24'b0, rdata0}, 32'd0);
    chk("rst_busy", {31'b0, busy0}, 32'd1);
    n0 = 0; n1 = 0; n2 = 0; n3 = 0; n4 = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy0) n0++;
      if (busy1) n1++;
      if (busy2) n2++;
      if (busy3) n3++;
      if (busy4) n4++;
      tick();
    end
    chk("init_busy_d0", n0, 16);
    chk("init_busy_d1", n1, 16);
    chk("init_busy_d2", n2, 16);
    chk("init_busy_d3", n3, 16);
    chk("init_busy_depth12", n4, 12);

    for (int a = 0; a < 16; a++) begin
      read(4'(a));
      chk($sformatf("clr_rvalid_%0d", a), {31'b0, rvalid0}, 32'd1);
      chk($sformatf("clr_rdata_%0d", a), {24'b0, rdata0}, 32'd0);
    end
    tick();
    chk("rvalid_pulse", {31'b0, rvalid0}, 32'd0);

    // Table: lane merge, collision, no-op write, hold between reads
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].wdata; wbe = vecs[i].wbe;
      re = vecs[i].re; raddr = vecs[i].raddr;
      tick();
      chk($sformatf("vec%0d_rvalid1", i), {31'b0, rvalid1}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_rdata1", i), rdata1, vecs[i].exp_d1);
      chk($sformatf("vec%0d_rvalid2", i), {31'b0, rvalid2}, {31'b0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_rdata2", i), {24'b0, rdata2}, {24'b0, vecs[i].exp_d2});
    end
    idle_inputs();
    tick();

    // OUT_REG=1: back-to-back reads
    write(4'd1, 32'h10, 4'hF);
    write(4'd2, 32'h20, 4'hF);
    write(4'd3, 32'h30, 4'hF);
    tick();
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    exp_q.push_back(8'h30);
    first_idx = -1;
    nvalid = 0;
    for (int c = 0; c < 7; c++) begin
      idle_inputs();
      if (c < 3) begin
        re = 1'b1;
        raddr = 4'(c + 1);
      end
      tick();
      if (rvalid3) begin
        if (first_idx < 0) first_idx = c;
        nvalid++;
        if (exp_q.size() == 0) chk("oreg_extra_result", {24'b0, rdata3}, 32'hFFFFFFFF);
        else chk($sformatf("oreg_data_%0d", nvalid), {24'b0, rdata3}, {24'b0, exp_q.pop_front()});
      end
    end
    chk("oreg_first_valid_cycle", first_idx, 1);
    chk("oreg_valid_count", nvalid, 3);
    chk("oreg_queue_empty", exp_q.size(), 0);

    // clr_req mid-stream
    for (int a = 0; a < 16; a++) write(4'(a), 32'hFFFFFFFF, 4'hF);
    idle_inputs();
    re = 1'b1; raddr = 4'd5;
    tick();
    chk("pre_clr_read_valid", {31'b0, rvalid0}, 32'd1);
    chk("pre_clr_read_data", {24'b0, rdata0}, 32'hFF);
    clr_req = 1'b1; re = 1'b1; raddr = 4'd6;
    we = 1'b1; waddr = 4'd6; wdata = 32'h0; wbe = 4'hF;
    tick();
    n0 = 0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (!busy0) break;
      n0++;
      if (rvalid0) bad++;
      we = 1'b1; waddr = 4'(c); wdata = 32'hABABABAB; wbe = 4'hF;
      re = 1'b1; raddr = 4'(c);
      clr_req = (c == 5);
      tick();
    end
    idle_inputs();
    chk("midclr_busy_cycles", n0, 16);
    chk("midclr_rvalid_while_busy", bad, 0);
    for (int a = 0; a < 16; a++) begin
      read(4'(a));
      chk($sformatf("post_clr_d0_%0d", a), {23'b0, rvalid0, rdata0}, 32'h100);
      chk($sformatf("post_clr_d1_%0d", a), rdata1, 32'h0);
    end

    // Non-power-of-two depth: top and beyond
    write(4'd11, 32'h66, 4'hF);
    write(4'd13, 32'h77, 4'hF);
    read(4'd11);
    chk("d12_last_valid", {31'b0, rvalid4}, 32'd1);
    chk("d12_last_data", {24'b0, rdata4}, 32'h66);
    read(4'd13);
    chk("d12_oob_valid", {31'b0, rvalid4}, 32'd1);
    chk("d12_oob_data", {24'b0, rdata4}, 32'h00);

    // Reset during a clear at count 9
    write(4'd2, 32'h3C, 4'hF);
    read(4'd2);
    chk("pre_rst_rdata0", {24'b0, rdata0}, 32'h3C);
    tick();
    chk("pre_rst_rdata3", {24'b0, rdata3}, 32'h3C);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 9; c++) tick();
    chk("busy_at_count9", {31'b0, busy0}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_rdata0", {24'b0, rdata0}, 32'd0);
    chk("rst_mid_rvalid0", {31'b0, rvalid0}, 32'd0);
    chk("rst_mid_rdata3", {24'b0, rdata3}, 32'd0);
    chk("rst_mid_rvalid3", {31'b0, rvalid3}, 32'd0);
    n0 = 0;
    for (int c = 0; c < 24; c++) begin
      if (busy0) n0++;
      tick();
    end
    chk("rst_mid_busy_cycles", n0, 16);
    read(4'd2);
    chk("rst_mid_read_after", {23'b0, rvalid0, rdata0}, 32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_sdp.md
# memory_sdp

Parametrised simple-dual-port synchronous RAM with byte-lane write enables, selectable read-during-write behaviour, an optional output register stage and a hardware clear sequencer. It replaces the fixed 16x8 register memory as the general storage primitive in the datapath, used wherever a buffer, lookup table or scratch store is needed. Reads return a valid-tagged result.

## Interface
- DATA_W, 8: word width in bits; must be a multiple of LANE_W.
- LANE_W, 8: bits per write-enable lane.
- ADDR_W, 4: address width.
- DEPTH, 2**ADDR_W: number of words.
- BYPASS, 1: read-during-write to the same address returns new data (1) or old data (0).
- OUT_REG, 0: adds one output pipeline register (1) or not (0).
- clk  in  1  clock; all logic is on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr_req  in  1  one-cycle request to zero the whole array.
- busy  out  1  clear sequence in progress.
- we  in  1  write enable.
- waddr  in  ADDR_W  write address.
- wdata  in  DATA_W  write data.
- wbe  in  DATA_W/LANE_W  per-lane write enable; lane i is wdata[i*LANE_W +: LANE_W].
- re  in  1  read enable.
- raddr  in  ADDR_W  read address.
- rdata  out  DATA_W  read data; holds its value between reads.
- rvalid  out  1  one-cycle pulse when rdata carries a new read result.

## Operation
- FSM states are IDLE and CLEAR.
- Reset:
  - Forces CLEAR with clear counter = 0.
  - Sets rdata = 0, rvalid = 0 and the pipeline valid bit = 0.
  - busy = 1 from the first cycle after reset.
- CLEAR:
  - Each cycle writes 0 to mem[counter], then increments the counter.
  - After writing DEPTH-1, goes to IDLE. A clear takes exactly DEPTH cycles.
- IDLE to CLEAR: on clr_req = 1, with the counter set to 0.
- clr_req while busy: ignored; the sequence is not restarted.
- Reset asserted during CLEAR restarts the sequence from address 0.
- While busy, or on the cycle clr_req is accepted:
  - we and re are ignored.
  - No read result is produced (rvalid stays 0).
- Write (IDLE, we = 1): only lanes with wbe[i] = 1 are updated; other lanes keep their contents. we = 1 with wbe = 0 is a no-op.
- Read (IDLE, re = 1): captures mem[raddr].
- Same-cycle read and write with raddr == waddr:
  - BYPASS = 1: the result is merged per lane; enabled lanes take wdata, disabled lanes take old contents.
  - BYPASS = 0: the result is the old contents.
- Addresses at or above DEPTH (non-power-of-two DEPTH):
  - Writes are dropped.
  - Reads return 0 with rvalid = 1.

## Timing
- OUT_REG = 0: a read accepted in cycle N gives rdata and rvalid at N+1.
- OUT_REG = 1: the result appears at N+2. Reads may be issued every cycle at full throughput in both modes.
- A write in cycle N is visible to a non-colliding read issued in N+1.
- busy rises the cycle after clr_req (or reset) and falls after the final clear write. The first accepted access is the cycle busy is 0.
- A read accepted in the cycle before clr_req still completes. With OUT_REG = 1, an in-flight result also completes.
- No combinational path from any input to any output.

## Structure
- Shared package `memory_pkg`:
  - FSM state enum (IDLE, CLEAR).
  - Lane-count helper constant: DATA_W/LANE_W.
- Sub-module `memory_clr_seq`: holds the clear FSM, the counter and busy generation. It outputs the clear write address and clear write enable to the array.
- The array, lane-merge/bypass mux and output stage stay in `memory_sdp`.

## Test plan
- Reset, then check the clear sequence (default params):
  - busy is held for 16 cycles.
  - Reads of addresses 0..15 then return 0x00, each with rvalid a cycle later.
- Byte-lane merge (DATA_W = 32):
  - Write 0xAABBCCDD with wbe = 4'b1111 to addr 3, then 0x11223344 with wbe = 4'b0101.
  - A read of addr 3 returns 0xAA22CC44.
- Collision (write 0x5A over 0x00 at addr 7, read addr 7 in the same cycle):
  - BYPASS = 1 returns 0x5A.
  - BYPASS = 0 returns 0x00; a read the next cycle returns 0x5A in both modes.
- OUT_REG = 1, back-to-back reads of addrs 1, 2, 3 holding 0x10, 0x20, 0x30:
  - rvalid is high for 3 consecutive cycles, starting 2 cycles after the first re.
  - Data arrives in order.
- clr_req mid-stream after writing 0xFF to every address:
  - we and re are ignored while busy.
  - clr_req asserted again while busy does not extend busy beyond DEPTH cycles.
  - All reads return 0x00 afterward.
- rst asserted at clear count 9:
  - The sequence restarts at 0 with busy held DEPTH more cycles.
  - rdata = 0 and rvalid = 0 the cycle after rst.
